// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode codes, sequence lengths and LED patterns for led_pattern_gen
package led_pattern_pkg;

  localparam int MAX_LED = 64;

  localparam logic [2:0] MODE_FILL_L  = 3'd0;
  localparam logic [2:0] MODE_FILL_R  = 3'd1;
  localparam logic [2:0] MODE_OUTWARD = 3'd2;
  localparam logic [2:0] MODE_INWARD  = 3'd3;
  localparam logic [2:0] MODE_CHASE   = 3'd4;
  localparam logic [2:0] MODE_BOUNCE  = 3'd5;
  localparam logic [2:0] MODE_BLINK   = 3'd6;
  localparam logic [2:0] MODE_OFF     = 3'd7;

  function automatic int seq_len(input logic [2:0] mode, input int n);
    case (mode)
      MODE_FILL_R:               seq_len = n + 1;
      MODE_OUTWARD, MODE_INWARD: seq_len = (n + 1) / 2 + 1;
      MODE_CHASE:                seq_len = n;
      MODE_BOUNCE:               seq_len = 2 * n - 2;
      MODE_BLINK:                seq_len = 2;
      MODE_OFF:                  seq_len = 1;
      default:                   seq_len = n + 1;
    endcase
  endfunction

  function automatic logic [MAX_LED-1:0] pattern(input logic [2:0] mode, input int idx, input int n);
    logic [MAX_LED-1:0] p;
    int d2;
    p = '0;
    for (int i = 0; i < MAX_LED; i++) begin
      // d2 is twice the distance of LED i from the bank centre; works for odd and even n
      d2 = 2 * i - (n - 1);
      if (d2 < 0) d2 = -d2;
      if (i < n) begin
        case (mode)
          MODE_FILL_R:  p[i] = (i >= n - idx);
          MODE_OUTWARD: p[i] = (d2 < 2 * idx);
          MODE_INWARD:  p[i] = (i < idx) || (i >= n - idx);
          MODE_CHASE:   p[i] = (i == idx);
          MODE_BOUNCE:  p[i] = (i == ((idx < n) ? idx : (2 * n - 2 - idx)));
          MODE_BLINK:   p[i] = (idx != 0);
          MODE_OFF:     p[i] = 1'b0;
          default:      p[i] = (i < idx);
        endcase
      end
    end
    pattern = p;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - step prescaler: tick every div_i+1 enabled clocks, sync clear
module led_tick_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] pcnt_q;
  logic [DIV_W-1:0] pcnt_d;

  // a count left above a freshly lowered div ends the period rather than running round
  assign tick_o = en_i && (pcnt_q >= div_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i || tick_o) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - N-LED pattern sequencer; LED_PATTERN_EXT_EN adds modes 4-7
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [N_LED-1:0] led,
  output logic             wrap
);

  localparam int IDX_W = $clog2(2 * N_LED);

  logic [2:0]         mode_eff;
  logic [2:0]         mode_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [N_LED-1:0]   led_q;
  logic [N_LED-1:0]   led_d;
  logic               wrap_q;
  logic               wrap_d;
  logic               mode_chg;
  logic               tick;
  logic [MAX_LED-1:0] pat;
  logic               unused_pat;

`ifdef LED_PATTERN_EXT_EN
  assign mode_eff = mode;
`else
  logic unused_mode_msb;
  assign unused_mode_msb = mode[2];
  assign mode_eff = {1'b0, mode[1:0]};
`endif

  assign mode_chg   = (mode_eff != mode_q);
  assign unused_pat = ^pat;

  led_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (ss),
    .clr_i  (mode_chg),
    .div_i  (div),
    .tick_o (tick)
  );

  // a mode change wins over a coincident tick and restarts the new sequence
  always_comb begin
    idx_d  = idx_q;
    led_d  = led_q;
    wrap_d = 1'b0;
    pat    = '0;
    if (mode_chg) begin
      idx_d = '0;
      pat   = pattern(mode_eff, 0, N_LED);
      led_d = pat[N_LED-1:0];
    end else if (tick) begin
      if (int'(idx_q) >= seq_len(mode_q, N_LED) - 1) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      pat   = pattern(mode_q, int'(idx_d), N_LED);
      led_d = pat[N_LED-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      idx_q  <= '0;
      led_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (mode_chg) mode_q <= mode_eff;
      idx_q  <= idx_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign led  = led_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen (N_LED=8, DIV_W=4)
module tb_led_pattern_gen;

  localparam int NL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ss = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] div = 4'd0;
  logic [7:0] led;
  logic       wrap;

  int n_chk = 0;
  int n_fail = 0;

  led_pattern_gen #(.N_LED(NL), .DIV_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ss    (ss),
    .mode  (mode),
    .div   (div),
    .led   (led),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic [2:0] mode;
    logic [3:0] div;
    logic [7:0] led;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  int         m_mode = 0;
  int         m_k = 0;
  int         m_cnt = 0;
  logic [7:0] m_led = 8'h00;
  logic       m_wrap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [2:0] m);
`ifdef LED_PATTERN_EXT_EN
    return int'(m);
`else
    return int'(m[1:0]);
`endif
  endfunction

  function automatic int mlen(input int m);
    case (m)
      2, 3:    return NL / 2 + 1;
      4:       return NL;
      5:       return 2 * NL - 2;
      6:       return 2;
      7:       return 1;
      default: return NL + 1;
    endcase
  endfunction

  function automatic logic [7:0] mpat(input int m, input int k);
    int lo;
    int v;
    lo = (1 << k) - 1;
    case (m)
      1:       v = lo << (NL - k);
      2:       v = ((1 << (2 * k)) - 1) << (NL / 2 - k);
      3:       v = lo | (lo << (NL - k));
      4:       v = 1 << k;
      5:       v = (k < NL) ? (1 << k) : (1 << (2 * NL - 2 - k));
      6:       v = (k != 0) ? 255 : 0;
      7:       v = 0;
      default: v = lo;
    endcase
    return v[7:0];
  endfunction

  task automatic model_edge();
    if (eff(mode) != m_mode) begin
      m_mode = eff(mode);
      m_k    = 0;
      m_cnt  = 0;
      m_led  = mpat(m_mode, 0);
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ss) begin
        if (m_cnt >= int'(div)) begin
          m_cnt  = 0;
          m_k    = (m_k + 1) % mlen(m_mode);
          m_wrap = (m_k == 0);
          m_led  = mpat(m_mode, m_k);
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_cnt = 0; m_led = 8'h00; m_wrap = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check("model_led", led, m_led);
    check("model_wrap", wrap, m_wrap);
  endtask

  task automatic add(input logic s, input logic [2:0] m, input logic [3:0] d,
                     input logic [7:0] l, input logic w);
    vec_t v;
    v.ss = s; v.mode = m; v.div = d; v.led = l; v.wrap = w;
    vecs.push_back(v);
  endtask

  initial begin
    int   cyc;
    int   first;
    int   got;
    logic [7:0] prev;

    // mode 0 fill from reset, ending with the wrap
    add(1, 0, 0, 8'h01, 0); add(1, 0, 0, 8'h03, 0); add(1, 0, 0, 8'h07, 0);
    add(1, 0, 0, 8'h0F, 0); add(1, 0, 0, 8'h1F, 0); add(1, 0, 0, 8'h3F, 0);
    add(1, 0, 0, 8'h7F, 0); add(1, 0, 0, 8'hFF, 0); add(1, 0, 0, 8'h00, 1);
    // outward then inward
    add(1, 2, 0, 8'h00, 0); add(1, 2, 0, 8'h18, 0); add(1, 2, 0, 8'h3C, 0);
    add(1, 2, 0, 8'h7E, 0); add(1, 2, 0, 8'hFF, 0); add(1, 2, 0, 8'h00, 1);
    add(1, 2, 0, 8'h18, 0);
    add(1, 3, 0, 8'h00, 0); add(1, 3, 0, 8'h81, 0); add(1, 3, 0, 8'hC3, 0);
    add(1, 3, 0, 8'hE7, 0); add(1, 3, 0, 8'hFF, 0); add(1, 3, 0, 8'h00, 1);
    // mode 0 to 07, then switch to mode 1 with no wrap
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h01, 0); add(1, 0, 0, 8'h03, 0);
    add(1, 0, 0, 8'h07, 0);
    add(1, 1, 0, 8'h00, 0); add(1, 1, 0, 8'h80, 0); add(1, 1, 0, 8'hC0, 0);
`ifdef LED_PATTERN_EXT_EN
    add(1, 4, 0, 8'h01, 0); add(1, 4, 0, 8'h02, 0); add(1, 4, 0, 8'h04, 0);
    add(1, 4, 0, 8'h08, 0); add(1, 4, 0, 8'h10, 0); add(1, 4, 0, 8'h20, 0);
    add(1, 4, 0, 8'h40, 0); add(1, 4, 0, 8'h80, 0); add(1, 4, 0, 8'h01, 1);
`else
    add(1, 5, 0, 8'hE0, 0); add(1, 5, 0, 8'hF0, 0);
    add(1, 4, 0, 8'h00, 0); add(1, 4, 0, 8'h01, 0); add(1, 4, 0, 8'h03, 0);
`endif

    #1;
    check("reset_led", led, 8'h00);
    check("reset_wrap", wrap, 1'b0);
    #199;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ss = vecs[i].ss; mode = vecs[i].mode; div = vecs[i].div;
      step();
      check($sformatf("vec%0d_led", i), led, vecs[i].led);
      check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wrap);
    end

    // freeze at 07 for 10 clocks, resume to 0F
    mode = 3'd2; ss = 1'b1; div = 4'd0;
    step();
    mode = 3'd0;
    step(); step(); step(); step();
    check("freeze_start", led, 8'h07);
    ss = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("freeze_hold", led, 8'h07);
      check("freeze_wrap", wrap, 1'b0);
    end
    ss = 1'b1;
    step();
    check("resume_led", led, 8'h0F);

    // div=3: step every 4 clocks, wrap every 36
    div = 4'd3;
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      step();
      got = int'(wrap);
    end
    check("div3_sync", got, 1);
    cyc = 0; first = 0; prev = led;
    for (int i = 0; i < 200; i++) begin
      step();
      cyc++;
      if (first == 0 && led !== prev) first = cyc;
      if (wrap) break;
    end
    check("div3_step_period", first, 4);
    check("div3_wrap_period", cyc, 36);

    // asynchronous reset mid-run at 3C
    div = 4'd0; mode = 3'd2;
    step(); step(); step();
    check("pre_reset_led", led, 8'h3C);
    #2 reset = 1'b1;
    #1;
    check("async_reset_led", led, 8'h00);
    check("async_reset_wrap", wrap, 1'b0);
    model_reset();
    step(); step();
    reset = 1'b0;
    step();
    check("restart_led0", led, 8'h00);
    step();
    check("restart_led1", led, 8'h18);

    // randomized run against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) mode = 3'($urandom_range(7));
      if ($urandom_range(31) == 0) div = 4'($urandom_range(3));
      ss = ($urandom_range(7) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
